dsram_resp: RTL and testbench

- Data-SRAM responder. It is the slave end of the cpu_data_* request interface that the EX stage drives.
- Holds the on-chip data memory and services byte-masked stores and word loads. Load data returns one cycle after the request, in time for the MEM stage.
- After reset it zero-initialises the array with a sweep FSM, flags out-of-window accesses, and can optionally store per-byte parity.

---
 rtl/dsram_pkg.sv | 17 +
 rtl/dsram_if.sv | 20 ++
 rtl/dsram_array.sv | 33 +++
 rtl/dsram_resp.sv | 155 +++++++++++++++
 tb/tb_dsram_resp.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder.
package dsram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DSRAM_ADDR_WD_DEF = 12;
  localparam int PAR_LANES         = 4;

  // Even parity: the stored bit makes the total count of ones in lane+bit even.
  function automatic logic lane_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dsram_if.sv
// cpu_data_* request/response bundle between the EX-stage initiator and the data SRAM.
interface dsram_if;
  import dsram_pkg::*;

  logic                 cpu_data_en;
  logic [PAR_LANES-1:0] cpu_data_wen;
  logic [31:0]          cpu_data_addr;
  logic [31:0]          cpu_data_wdata;
  logic [31:0]          cpu_data_rdata;

  modport master (
    output cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
    input  cpu_data_rdata
  );

  modport slave (
    input  cpu_data_en, cpu_data_wen, cpu_data_addr, cpu_data_wdata,
    output cpu_data_rdata
  );
endinterface

// File: rtl/dsram_array.sv
// Single-port synchronous read-first array with per-lane write enables.
module dsram_array
  import dsram_pkg::*;
#(
  parameter int ADDR_WD = DSRAM_ADDR_WD_DEF,
  parameter int LW      = 8
) (
  input  logic                          clk,
  input  logic [ADDR_WD-1:0]            addr,
  input  logic [PAR_LANES-1:0]          we,
  input  logic [PAR_LANES-1:0][LW-1:0]  wdata,
  input  logic                          re,
  output logic [PAR_LANES-1:0][LW-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_WD;

  logic [PAR_LANES-1:0][LW-1:0] mem_q [DEPTH];
  logic [PAR_LANES-1:0][LW-1:0] rdata_q;

  // Read samples the old word before this edge's lane writes land.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[addr];
    end
    for (int i = 0; i < PAR_LANES; i++) begin
      if (we[i]) begin
        mem_q[addr][i] <= wdata[i];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dsram_resp.sv
// Data-SRAM responder: zero sweep after reset, byte-masked stores, read-first loads,
// out-of-window capture. Define DSRAM_PARITY_EN to store and check per-byte parity.
module dsram_resp
  import dsram_pkg::*;
#(
  parameter int          ADDR_WD   = DSRAM_ADDR_WD_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  dsram_if.slave      cpu,
  output logic        init_done,
  output logic        addr_err,
  output logic [31:0] err_addr,
  input  logic        par_inj,
  output logic        par_err
);
`ifdef DSRAM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif

  state_e                       state_q, state_d;
  logic [ADDR_WD-1:0]           cnt_q, cnt_d;
  logic                         sel_q, sel_d;
  logic                         chk_q, chk_d;
  logic                         addr_err_q, addr_err_d;
  logic [31:0]                  err_addr_q, err_addr_d;
  logic                         in_win, req;
  logic [ADDR_WD-1:0]           idx, mem_addr;
  logic [PAR_LANES-1:0]         mem_we;
  logic                         mem_re;
  logic [PAR_LANES-1:0][LW-1:0] mem_wdata, mem_rdata;
  logic [31:0]                  rd_word;

  assign in_win = (cpu.cpu_data_addr[31:ADDR_WD+2] == BASE_ADDR[31:ADDR_WD+2]);
  assign idx    = cpu.cpu_data_addr[ADDR_WD+1:2];
  assign req    = cpu.cpu_data_en | (|cpu.cpu_data_wen);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    chk_d      = 1'b0;
    addr_err_d = addr_err_q;
    err_addr_d = err_addr_q;
    mem_addr   = idx;
    mem_we     = '0;
    mem_re     = 1'b0;
    if (!reset) begin
      if (state_q == INIT) begin
        mem_addr = cnt_q;
        mem_we   = '1;
        cnt_d    = cnt_q + ADDR_WD'(1);
        if (cnt_q == '1) begin
          state_d = READY;
        end
      end else if (in_win) begin
        mem_we = cpu.cpu_data_wen;
        mem_re = cpu.cpu_data_en;
        chk_d  = cpu.cpu_data_en;
        if (cpu.cpu_data_en) begin
          sel_d = 1'b1;
        end
      end else if (req) begin
        addr_err_d = 1'b1;
        if (!addr_err_q) begin
          err_addr_d = cpu.cpu_data_addr;
        end
        // An out-of-window load presents zero instead of the array output.
        if (cpu.cpu_data_en) begin
          sel_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      chk_q      <= 1'b0;
      addr_err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      chk_q      <= chk_d;
      addr_err_q <= addr_err_d;
      err_addr_q <= err_addr_d;
    end
  end

`ifdef DSRAM_PARITY_EN
  logic [PAR_LANES-1:0] mism;
  logic                 par_err_q, par_err_d;
`endif

  for (genvar gi = 0; gi < PAR_LANES; gi++) begin : g_lane
    logic [7:0] wbyte;
    assign wbyte              = (state_q == INIT) ? 8'h00 : cpu.cpu_data_wdata[8*gi +: 8];
    assign rd_word[8*gi +: 8] = mem_rdata[gi][7:0];
`ifdef DSRAM_PARITY_EN
    assign mem_wdata[gi] = {lane_par(wbyte) ^ (par_inj & (state_q == READY)), wbyte};
    assign mism[gi]      = mem_rdata[gi][8] ^ lane_par(mem_rdata[gi][7:0]);
`else
    assign mem_wdata[gi] = wbyte;
`endif
  end

  dsram_array #(
    .ADDR_WD (ADDR_WD),
    .LW      (LW)
  ) u_array (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

`ifdef DSRAM_PARITY_EN
  // Flag is visible in the same cycle the faulty word is presented, then held.
  always_comb begin
    par_err_d = par_err_q | (chk_q & (|mism));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_d;

  logic unused_ok;
  assign unused_ok = &{1'b0, cpu.cpu_data_addr[1:0]};
`else
  assign par_err = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, par_inj, cpu.cpu_data_addr[1:0]};
`endif

  assign cpu.cpu_data_rdata = sel_q ? rd_word : 32'h0;
  assign init_done          = (state_q == READY);
  assign addr_err           = addr_err_q;
  assign err_addr           = err_addr_q;
endmodule

// File: tb/tb_dsram_resp.sv
// Self-checking bench for dsram_resp (ADDR_WD=4): directed scenarios plus random traffic
// compared every cycle against a word-array reference model.
module tb_dsram_resp;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DSRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        par_inj = 1'b0;
  logic        init_done, addr_err, par_err;
  logic [31:0] err_addr;

  dsram_if bus();

  dsram_resp #(.ADDR_WD(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus),
    .init_done (init_done),
    .addr_err  (addr_err),
    .err_addr  (err_addr),
    .par_inj   (par_inj),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_par [DEPTH];
  int          m_low;
  logic [31:0] e_rdata, e_eaddr, m_a;
  logic [3:0]  m_k;
  logic        e_done, e_aerr, e_perr;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_low   = 0;
      e_done  = 1'b0;
      e_rdata = 32'h0;
      e_aerr  = 1'b0;
      e_eaddr = 32'h0;
      e_perr  = 1'b0;
      model_live = 1'b1;
    end else if (!e_done) begin
      m_low++;
      if (m_low == DEPTH) begin
        e_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i] = 32'h0;
          m_par[i] = 4'h0;
        end
      end
    end else begin
      m_a = bus.cpu_data_addr;
      m_k = m_a[5:2];
      if (m_a[31:6] != 26'h0) begin
        if (bus.cpu_data_en || bus.cpu_data_wen != 4'h0) begin
          if (!e_aerr) e_eaddr = m_a;
          e_aerr = 1'b1;
          if (bus.cpu_data_en) e_rdata = 32'h0;
        end
      end else begin
        if (bus.cpu_data_en) begin
          e_rdata = m_mem[m_k];
          for (int b = 0; b < 4; b++)
            if (PAR && (m_par[m_k][b] != ^m_mem[m_k][8*b +: 8])) e_perr = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
          if (bus.cpu_data_wen[b]) begin
            m_mem[m_k][8*b +: 8] = bus.cpu_data_wdata[8*b +: 8];
            m_par[m_k][b]        = (^bus.cpu_data_wdata[8*b +: 8]) ^ par_inj;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("rdata", bus.cpu_data_rdata, e_rdata);
      chk("init_done", {31'h0, init_done}, {31'h0, e_done});
      chk("addr_err", {31'h0, addr_err}, {31'h0, e_aerr});
      chk("err_addr", err_addr, e_eaddr);
      chk("par_err", {31'h0, par_err}, {31'h0, e_perr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic inj);
    bus.cpu_data_en    = en;
    bus.cpu_data_wen   = wen;
    bus.cpu_data_addr  = addr;
    bus.cpu_data_wdata = wdata;
    par_inj            = inj;
  endtask

  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic inj);
    @(posedge clk);
    #1;
    drive(en, wen, addr, wdata, inj);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      if (init_done) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  logic [31:0] ra;
  int r;

  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.cpu_data_rdata, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_par_err", {31'h0, par_err}, 32'h0);
    reset = 1'b0;
    wait_init(n);
    chk("init_latency", 32'(n), 32'd16);

    step(1'b1, 4'h0, 32'h3C, 32'h0, 1'b0);
    idle();
    chk("load_3c_zero", bus.cpu_data_rdata, 32'h0);

    step(1'b0, 4'hF, 32'h8, 32'hDEADBEEF, 1'b0);
    step(1'b0, 4'b0010, 32'h8, 32'h0000_5500, 1'b0);
    step(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
    idle();
    chk("byte_merge", bus.cpu_data_rdata, 32'hDEAD55EF);

    step(1'b0, 4'hF, 32'h4, 32'h11111111, 1'b0);
    step(1'b1, 4'hF, 32'h4, 32'h22222222, 1'b0);
    idle();
    chk("read_first_old", bus.cpu_data_rdata, 32'h11111111);
    step(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
    idle();
    chk("read_first_new", bus.cpu_data_rdata, 32'h22222222);

    step(1'b0, 4'hF, 32'h100, 32'hCAFEF00D, 1'b0);
    step(1'b1, 4'h0, 32'h200, 32'h0, 1'b0);
    idle();
    chk("oob_addr_err", {31'h0, addr_err}, 32'h1);
    chk("oob_err_addr_first", err_addr, 32'h100);
    chk("oob_rdata_zero", bus.cpu_data_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    idle();
    chk("oob_store_dropped", bus.cpu_data_rdata, 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst2_err_addr", err_addr, 32'h0);
    chk("rst2_init_done", {31'h0, init_done}, 32'h0);
    drive(1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 1'b0);
    wait_init(n);
    chk("init_latency2", 32'(n), 32'd16);
    step(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    idle();
    chk("init_store_ignored", bus.cpu_data_rdata, 32'h0);

`ifdef DSRAM_PARITY_EN
    step(1'b0, 4'b0001, 32'hC, 32'h0000_00A5, 1'b1);
    step(1'b1, 4'h0, 32'hC, 32'h0, 1'b0);
    idle();
    chk("par_err_set", {31'h0, par_err}, 32'h1);
    chk("par_rdata_unmod", bus.cpu_data_rdata, 32'h0000_00A5);
    step(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
    idle();
    chk("par_err_sticky", {31'h0, par_err}, 32'h1);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 499) == 0);
      r = $urandom_range(0, 9);
      if (r < 8)       ra = 32'($urandom_range(0, 63));
      else if (r == 8) ra = 32'($urandom_range(64, 1023));
      else             ra = $urandom;
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            ra, $urandom, ($urandom_range(0, 15) == 0));
    end
    idle();
    reset = 1'b0;
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
